// File: rtl/alu_pkg.sv
// Shared definitions for the add/sub pipeline: FSM state encoding and counter width.
package alu_pkg;

  localparam int unsigned OP_COUNT_W = 16;

  // EMPTY: result register holds nothing; FULL: result register holds a result.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational N-bit two's-complement adder/subtractor with signed overflow.
// Ports:
//   a, b  : N-bit operands
//   sub   : 1 = a-b, 0 = a+b
//   s     : N-bit wrapped result
//   ovf   : carry into MSB XOR carry out of MSB
module addsub_core #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         ovf
);

  logic [N-1:0] bx;
  logic [N-1:0] low_sum;
  logic [1:0]   msb_sum;

  assign bx = b ^ {N{sub}};

  // Lower N-1 bits; bit N-1 of low_sum is the carry into the MSB.
  assign low_sum = N'({1'b0, a[N-2:0]}) + N'({1'b0, bx[N-2:0]}) + N'(sub);

  // MSB column; msb_sum[1] is the carry out of the MSB.
  assign msb_sum = 2'(a[N-1]) + 2'(bx[N-1]) + 2'(low_sum[N-1]);

  assign s   = {msb_sum[0], low_sum[N-2:0]};
  assign ovf = low_sum[N-1] ^ msb_sum[1];

endmodule

// File: rtl/addsub_pipe.sv
// Single-stage registered add/sub pipeline with valid/ready handshake,
// sticky overflow flag and consumed-result counter.
// Optional feature: define ADDSUB_PIPE_SAT_EN to saturate overflowing results.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready is combinational)
//   in_a, in_b, in_sub    : operands and operation select (1 = a-b)
//   out_valid/out_ready   : downstream handshake
//   out_s, out_ovf        : registered result and its signed overflow
//   ovf_sticky/clr_sticky : sticky overflow flag and its synchronous clear
//   op_count              : results consumed downstream, modulo 2^16
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_a,
  input  logic [N-1:0]          in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_s,
  output logic                  out_ovf,
  output logic                  ovf_sticky,
  input  logic                  clr_sticky,
  output logic [OP_COUNT_W-1:0] op_count
);

  state_t                  state_q, state_d;
  logic [N-1:0]            s_q, s_d;
  logic                    ovf_q, ovf_d;
  logic                    sticky_q, sticky_d;
  logic [OP_COUNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]            core_s;
  logic                    core_ovf;
  logic [N-1:0]            res_s;
  logic                    accept;

  addsub_core #(.N(N)) u_core (
    .a   (in_a),
    .b   (in_b),
    .sub (in_sub),
    .s   (core_s),
    .ovf (core_ovf)
  );

`ifdef ADDSUB_PIPE_SAT_EN
  // On overflow the wrapped MSB is the inverse of the true sign.
  assign res_s = !core_ovf   ? core_s :
                 core_s[N-1] ? {1'b0, {(N-1){1'b1}}} :
                               {1'b1, {(N-1){1'b0}}};
`else
  assign res_s = core_s;
`endif

  assign in_ready   = (state_q == EMPTY) | out_ready;
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == FULL);
  assign out_s      = s_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;
  assign op_count   = cnt_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      s_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and register-load logic.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      s_d   = res_s;
      ovf_d = core_ovf;
    end

    if (out_valid && out_ready) cnt_d = cnt_q + OP_COUNT_W'(1);

    // A setting accept wins over a coincident clear.
    if (clr_sticky)          sticky_d = 1'b0;
    if (accept && core_ovf)  sticky_d = 1'b1;
  end

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_s;
  logic          out_ovf;
  logic          ovf_sticky;
  logic          clr_sticky;
  logic [15:0]   op_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic        mv;
  logic [15:0] m_s;
  logic        m_ovf;
  logic        m_sticky;
  logic [15:0] m_cnt;
  logic        obs_rdy;
  logic        exp_rdy;

  always #5 clk = ~clk;

  addsub_pipe #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  // Arithmetic on plain integers, then range check for overflow.
  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output logic [15:0] s, output logic ovf);
    int fa, fb, full;
    fa   = int'($signed(a));
    fb   = int'($signed(b));
    full = sub ? fa - fb : fa + fb;
    ovf  = (full > 32767) || (full < -32768);
    s    = full[15:0];
`ifdef ADDSUB_PIPE_SAT_EN
    if (ovf) s = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
  endtask

  task automatic model_reset();
    mv = 1'b0; m_s = '0; m_ovf = 1'b0; m_sticky = 1'b0; m_cnt = '0;
  endtask

  // Drive one cycle of inputs, sample in_ready before the edge, advance the model.
  task automatic drive_cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic ordy, input logic clr);
    logic acc, cons, n_ovf;
    logic [15:0] n_s;
    in_valid = v; in_a = a; in_b = b; in_sub = sub; out_ready = ordy; clr_sticky = clr;
    #1;
    obs_rdy = in_ready;
    exp_rdy = !mv || ordy;
    @(posedge clk);
    acc  = v && exp_rdy;
    cons = mv && ordy;
    if (cons) m_cnt = m_cnt + 16'd1;
    model_op(a, b, sub, n_s, n_ovf);
    if (clr) m_sticky = 1'b0;
    if (acc) begin
      mv = 1'b1; m_s = n_s; m_ovf = n_ovf;
      if (n_ovf) m_sticky = 1'b1;
    end else if (cons) begin
      mv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0; out_ready = 0; clr_sticky = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_s !== 16'h0 || out_ovf !== 1'b0 ||
        ovf_sticky !== 1'b0 || op_count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b s=%h o=%b st=%b c=%h exp all zero",
               out_valid, out_s, out_ovf, ovf_sticky, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    drive_cycle(1, 16'd1000, 16'd999, 1, 1, 0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_s !== 16'h0001 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_1000_999 got v=%b s=%h o=%b exp v=1 s=0001 o=0", out_valid, out_s, out_ovf);
    end
    drive_cycle(1, 16'd1000, 16'd999, 0, 1, 0);
    n_cmp++;
    if (op_count !== 16'd1) begin
      n_bad++;
      $display("FAIL count_after_first got %0d exp 1", op_count);
    end
    n_cmp++;
    if (out_s !== 16'h07CF || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL add_1000_999 got s=%h o=%b exp s=07cf o=0", out_s, out_ovf);
    end
    drive_cycle(1, 16'h7FFF, 16'h0001, 0, 1, 0);
    n_cmp++;
`ifdef ADDSUB_PIPE_SAT_EN
    if (out_s !== 16'h7FFF || out_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL pos_ovf got s=%h o=%b st=%b exp s=7fff o=1 st=1", out_s, out_ovf, ovf_sticky);
    end
`else
    if (out_s !== 16'h8000 || out_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL pos_ovf got s=%h o=%b st=%b exp s=8000 o=1 st=1", out_s, out_ovf, ovf_sticky);
    end
`endif
    drive_cycle(1, 16'h8000, 16'h0001, 1, 1, 0);
    n_cmp++;
`ifdef ADDSUB_PIPE_SAT_EN
    if (out_s !== 16'h8000 || out_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL neg_ovf got s=%h o=%b exp s=8000 o=1", out_s, out_ovf);
    end
`else
    if (out_s !== 16'h7FFF || out_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL neg_ovf got s=%h o=%b exp s=7fff o=1", out_s, out_ovf);
    end
`endif
    drive_cycle(0, 16'h0, 16'h0, 0, 1, 0);
    n_cmp++;
    if (out_valid !== 1'b0 || op_count !== m_cnt || op_count !== 16'd4) begin
      n_bad++;
      $display("FAIL drain got v=%b c=%0d exp v=0 c=4", out_valid, op_count);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    logic [15:0] cnt0;
    drive_cycle(1, 16'd10, 16'd20, 0, 0, 0);
    held = m_s;
    cnt0 = op_count;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 16'($urandom), 16'($urandom), 1'($urandom), 0, 0);
      n_cmp++;
      if (obs_rdy !== 1'b0 || out_s !== held || op_count !== cnt0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got rdy=%b s=%h c=%0d v=%b exp rdy=0 s=%h c=%0d v=1",
                 i, obs_rdy, out_s, op_count, out_valid, held, cnt0);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 16'($urandom), 16'($urandom), 1'($urandom), 1, 0);
      n_cmp++;
      if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || out_s !== m_s ||
          out_ovf !== m_ovf || op_count !== 16'(cnt0 + 16'(i + 1))) begin
        n_bad++;
        $display("FAIL bp_b2b[%0d] got rdy=%b v=%b s=%h o=%b c=%0d exp s=%h o=%b c=%0d",
                 i, obs_rdy, out_valid, out_s, out_ovf, op_count, m_s, m_ovf, cnt0 + i + 1);
      end
    end
  endtask

  task automatic test_sticky();
    drive_cycle(1, 16'd5, 16'd6, 0, 1, 1);
    n_cmp++;
    if (ovf_sticky !== 1'b0 || m_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sticky_clear got %b exp 0", ovf_sticky);
    end
    drive_cycle(1, 16'h7000, 16'h7000, 0, 1, 1);
    n_cmp++;
    if (ovf_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL sticky_set_wins got %b exp 1", ovf_sticky);
    end
    drive_cycle(0, 16'h0, 16'h0, 0, 1, 0);
    n_cmp++;
    if (ovf_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL sticky_hold got %b exp 1", ovf_sticky);
    end
    drive_cycle(0, 16'h7FFF, 16'h7FFF, 0, 1, 1);
    n_cmp++;
    if (ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL sticky_idle_clear got %b exp 0", ovf_sticky);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
      drive_cycle(1'($urandom_range(0, 3) != 0), a, b, 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      n_cmp++;
      if (obs_rdy !== exp_rdy || out_valid !== mv || op_count !== m_cnt ||
          ovf_sticky !== m_sticky || (mv && (out_s !== m_s || out_ovf !== m_ovf))) begin
        n_bad++;
        $display("FAIL rand[%0d] got rdy=%b v=%b s=%h o=%b st=%b c=%h exp rdy=%b v=%b s=%h o=%b st=%b c=%h",
                 i, obs_rdy, out_valid, out_s, out_ovf, ovf_sticky, op_count,
                 exp_rdy, mv, m_s, m_ovf, m_sticky, m_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 16'd3, 16'd4, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || op_count !== 16'h0 || out_s !== 16'h0 || ovf_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b c=%h s=%h st=%b exp all zero",
               out_valid, op_count, out_s, ovf_sticky);
    end
    model_reset();
    in_valid = 0; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'h0) begin
      n_bad++;
      $display("FAIL post_reset got rdy=%b v=%b c=%h exp rdy=1 v=0 c=0", in_ready, out_valid, op_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 65536; i++) drive_cycle(1, 16'(i), 16'd1, 0, 1, 0);
    n_cmp++;
    if (op_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_ffff got %h exp ffff", op_count);
    end
    drive_cycle(0, 16'h0, 16'h0, 0, 1, 0);
    n_cmp++;
    if (op_count !== 16'h0000 || m_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_zero got %h exp 0000", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_sticky();
    test_random();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
